// File: rtl/pcie_tlp_rx_engine.sv
// Receive-side TLP parser for the 128-bit Xilinx PCIe AXIS RX channel.
// Decodes 3DW MRd32/MWr32 for the PIO target and Cpl/CplD for DMA read returns.
module pcie_tlp_rx_engine #(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  output logic                    req_compl,
  output logic                    req_compl_wd,
  output logic [2:0]              req_tc,
  output logic                    req_td,
  output logic                    req_ep,
  output logic [1:0]              req_attr,
  output logic [9:0]              req_len,
  output logic [15:0]             req_rid,
  output logic [7:0]              req_tag,
  output logic [7:0]              req_be,
  output logic [31:0]             req_addr,
  input  logic                    compl_done,
  output logic                    wr_en,
  output logic [31:0]             wr_addr,
  output logic [3:0]              wr_be,
  output logic [31:0]             wr_data,
  input  logic                    wr_busy,
  output logic [P_DATA_WIDTH-1:0] cpl_data,
  output logic [P_KEEP_WIDTH-1:0] cpl_keep,
  output logic                    cpl_valid,
  output logic                    cpl_last,
  output logic [7:0]              cpl_tag,
  output logic                    cpl_err
);

  localparam logic [6:0] FT_MRD32 = 7'b0000000;
  localparam logic [6:0] FT_MWR32 = 7'b1000000;
  localparam logic [6:0] FT_CPLD  = 7'b1001010;
  localparam logic [6:0] FT_CPL   = 7'b0001010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCARD,
    S_REQ_WAIT,
    S_MWR_WAIT,
    S_CPLD_STREAM,
    S_CPLD_FLUSH
  } state_t;

  state_t      state_q;
  logic        tready_q;
  logic        mrd_pend_q;
  logic        mwr_more_q;

  logic        req_compl_q;
  logic        req_compl_wd_q;
  logic [2:0]  req_tc_q;
  logic        req_td_q;
  logic        req_ep_q;
  logic [1:0]  req_attr_q;
  logic [9:0]  req_len_q;
  logic [15:0] req_rid_q;
  logic [7:0]  req_tag_q;
  logic [7:0]  req_be_q;
  logic [31:0] req_addr_q;

  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [3:0]  wr_be_q;
  logic [31:0] wr_data_q;

  logic [127:0] cpl_data_q;
  logic [15:0]  cpl_keep_q;
  logic         cpl_valid_q;
  logic         cpl_last_q;
  logic [7:0]   cpl_tag_q;
  logic         cpl_err_q;
  logic [31:0]  scratch_q;
  logic [9:0]   dw_rem_q;

  logic        beat;
  logic [6:0]  fmt_type;
  logic [9:0]  hdr_len;
  logic [2:0]  hdr_status;
  logic        hdr_ep;
  logic [31:0] hdr_dw3;
  logic [31:0] hdr_addr;
  logic        unused_in;

  assign beat       = m_axis_rx_tvalid & tready_q;
  assign fmt_type   = m_axis_rx_tdata[30:24];
  assign hdr_len    = m_axis_rx_tdata[9:0];
  assign hdr_status = m_axis_rx_tdata[47:45];
  assign hdr_ep     = m_axis_rx_tdata[14];
  assign hdr_dw3    = m_axis_rx_tdata[127:96];
  assign hdr_addr   = {m_axis_rx_tdata[95:66], 2'b00};
  assign unused_in  = ^{m_axis_rx_tkeep, m_axis_rx_tdata};

  // Byte enables for a final word holding 1 + rem DWs (scratch plus rem more).
  function automatic logic [15:0] keep_for(input logic [9:0] rem);
    case (rem[1:0])
      2'd0:    keep_for = 16'h000F;
      2'd1:    keep_for = 16'h00FF;
      2'd2:    keep_for = 16'h0FFF;
      default: keep_for = 16'hFFFF;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      tready_q       <= 1'b1;
      mrd_pend_q     <= 1'b0;
      mwr_more_q     <= 1'b0;
      req_compl_q    <= 1'b0;
      req_compl_wd_q <= 1'b0;
      req_tc_q       <= '0;
      req_td_q       <= 1'b0;
      req_ep_q       <= 1'b0;
      req_attr_q     <= '0;
      req_len_q      <= '0;
      req_rid_q      <= '0;
      req_tag_q      <= '0;
      req_be_q       <= '0;
      req_addr_q     <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_be_q        <= '0;
      wr_data_q      <= '0;
      cpl_data_q     <= '0;
      cpl_keep_q     <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_last_q     <= 1'b0;
      cpl_tag_q      <= '0;
      cpl_err_q      <= 1'b0;
      scratch_q      <= '0;
      dw_rem_q       <= '0;
    end else begin
      req_compl_q <= 1'b0;
      wr_en_q     <= 1'b0;
      cpl_valid_q <= 1'b0;
      cpl_last_q  <= 1'b0;
      cpl_err_q   <= 1'b0;
      if (mrd_pend_q && compl_done) mrd_pend_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (beat) begin
            case (fmt_type)
              FT_MRD32: begin
                req_compl_q    <= 1'b1;
                req_compl_wd_q <= 1'b1;
                req_tc_q       <= m_axis_rx_tdata[22:20];
                req_td_q       <= m_axis_rx_tdata[15];
                req_ep_q       <= m_axis_rx_tdata[14];
                req_attr_q     <= m_axis_rx_tdata[13:12];
                req_len_q      <= hdr_len;
                req_rid_q      <= m_axis_rx_tdata[63:48];
                req_tag_q      <= m_axis_rx_tdata[47:40];
                req_be_q       <= m_axis_rx_tdata[39:32];
                req_addr_q     <= hdr_addr;
                mrd_pend_q     <= 1'b1;
                // A multi-beat MRd is drained first; the parser then parks until compl_done.
                state_q        <= m_axis_rx_tlast ? S_REQ_WAIT : S_DISCARD;
                tready_q       <= !m_axis_rx_tlast;
              end
              FT_MWR32: begin
                if (hdr_len == 10'd1) begin
                  wr_addr_q <= hdr_addr;
                  wr_be_q   <= m_axis_rx_tdata[35:32];
                  wr_data_q <= hdr_dw3;
                  if (!wr_busy) begin
                    wr_en_q <= 1'b1;
                    if (!m_axis_rx_tlast) state_q <= S_DISCARD;
                  end else begin
                    mwr_more_q <= !m_axis_rx_tlast;
                    state_q    <= S_MWR_WAIT;
                    tready_q   <= 1'b0;
                  end
                end else if (!m_axis_rx_tlast) begin
                  state_q <= S_DISCARD;
                end
              end
              FT_CPLD, FT_CPL: begin
                cpl_tag_q <= m_axis_rx_tdata[79:72];
                if (hdr_status != 3'b000 || hdr_ep) begin
                  cpl_err_q <= 1'b1;
                  if (!m_axis_rx_tlast) state_q <= S_DISCARD;
                end else if (fmt_type == FT_CPL) begin
                  if (!m_axis_rx_tlast) state_q <= S_DISCARD;
                end else begin
                  scratch_q <= hdr_dw3;
                  dw_rem_q  <= hdr_len - 10'd1;
                  if (m_axis_rx_tlast) begin
                    cpl_data_q  <= {96'd0, hdr_dw3};
                    cpl_keep_q  <= 16'h000F;
                    cpl_valid_q <= 1'b1;
                    cpl_last_q  <= 1'b1;
                  end else begin
                    state_q <= S_CPLD_STREAM;
                  end
                end
              end
              default: begin
                if (!m_axis_rx_tlast) state_q <= S_DISCARD;
              end
            endcase
          end
        end

        S_DISCARD: begin
          if (beat && m_axis_rx_tlast) begin
            if (mrd_pend_q && !compl_done) begin
              state_q  <= S_REQ_WAIT;
              tready_q <= 1'b0;
            end else begin
              state_q  <= S_IDLE;
              tready_q <= 1'b1;
            end
          end
        end

        S_REQ_WAIT: begin
          if (compl_done || !mrd_pend_q) begin
            state_q  <= S_IDLE;
            tready_q <= 1'b1;
          end
        end

        S_MWR_WAIT: begin
          if (!wr_busy) begin
            wr_en_q  <= 1'b1;
            state_q  <= mwr_more_q ? S_DISCARD : S_IDLE;
            tready_q <= 1'b1;
          end
        end

        S_CPLD_STREAM: begin
          if (beat) begin
            // Header occupied DW0-2, so each output word is the held DW plus the low 3 DWs of this beat.
            cpl_data_q  <= {m_axis_rx_tdata[95:0], scratch_q};
            cpl_valid_q <= 1'b1;
            scratch_q   <= hdr_dw3;
            if (dw_rem_q >= 10'd4) begin
              cpl_keep_q <= 16'hFFFF;
              dw_rem_q   <= dw_rem_q - 10'd4;
              if (m_axis_rx_tlast) begin
                state_q  <= S_CPLD_FLUSH;
                tready_q <= 1'b0;
              end
            end else begin
              cpl_keep_q <= keep_for(dw_rem_q);
              cpl_last_q <= 1'b1;
              dw_rem_q   <= '0;
              state_q    <= m_axis_rx_tlast ? S_IDLE : S_DISCARD;
            end
          end
        end

        S_CPLD_FLUSH: begin
          cpl_data_q  <= {96'd0, scratch_q};
          cpl_keep_q  <= 16'h000F;
          cpl_valid_q <= 1'b1;
          cpl_last_q  <= 1'b1;
          state_q     <= S_IDLE;
          tready_q    <= 1'b1;
        end

        default: begin
          state_q  <= S_IDLE;
          tready_q <= 1'b1;
        end
      endcase
    end
  end

  assign m_axis_rx_tready = tready_q;
  assign req_compl        = req_compl_q;
  assign req_compl_wd     = req_compl_wd_q;
  assign req_tc           = req_tc_q;
  assign req_td           = req_td_q;
  assign req_ep           = req_ep_q;
  assign req_attr         = req_attr_q;
  assign req_len          = req_len_q;
  assign req_rid          = req_rid_q;
  assign req_tag          = req_tag_q;
  assign req_be           = req_be_q;
  assign req_addr         = req_addr_q;
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_be            = wr_be_q;
  assign wr_data          = wr_data_q;
  assign cpl_data         = cpl_data_q;
  assign cpl_keep         = cpl_keep_q;
  assign cpl_valid        = cpl_valid_q;
  assign cpl_last         = cpl_last_q;
  assign cpl_tag          = cpl_tag_q;
  assign cpl_err          = cpl_err_q;

endmodule
